// File: rtl/dma_transfer_ctrl.sv
// Single-channel DMA timing/control FSM: bus arbitration, address/read/write phases, counters, TC.
// Optional feature macro DMA_AUTOINIT_EN: reload addresses and count from the loaded bases at TC.
module dma_transfer_ctrl #(
   parameter int AW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          RESET,
   input  logic          DREQ,
   input  logic          HLDA,
   input  logic          READY,
   input  logic          load,
   input  logic [AW-1:0] src_base,
   input  logic [AW-1:0] dst_base,
   input  logic [CW-1:0] count_base,
   input  logic [1:0]    mode,
   input  logic          addr_dec,
   output logic          HRQ,
   output logic [AW-1:0] ADDR,
   output logic          IOR,
   output logic          IOW,
   output logic          MEMR,
   output logic          MEMW,
   output logic          MEMRW,
   output logic          MemToMem,
   output logic          Data_flag,
   output logic          IReady,
   output logic          TC,
   output logic          busy,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_ADR  = 3'd2,
      S_RD   = 3'd3,
      S_WR   = 3'd4,
      S_UPD  = 3'd5
   } state_t;

   localparam logic [1:0]    MODE_IO2MEM  = 2'b01;
   localparam logic [1:0]    MODE_MEM2IO  = 2'b10;
   localparam logic [1:0]    MODE_MEM2MEM = 2'b11;
   localparam logic [AW-1:0] A_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    mode_q, mode_d;
   logic          busy_q, busy_d;
   logic          hlda_lost_q, hlda_lost_d;

`ifdef DMA_AUTOINIT_EN
   logic [AW-1:0] src_base_q, src_base_d;
   logic [AW-1:0] dst_base_q, dst_base_d;
   logic [CW-1:0] cnt_base_q, cnt_base_d;

   always_comb begin
      src_base_d = src_base_q;
      dst_base_d = dst_base_q;
      cnt_base_d = cnt_base_q;
      if (state_q == S_IDLE && load) begin
         src_base_d = src_base;
         dst_base_d = dst_base;
         cnt_base_d = count_base;
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         src_base_q <= '0;
         dst_base_q <= '0;
         cnt_base_q <= '0;
      end else begin
         src_base_q <= src_base_d;
         dst_base_q <= dst_base_d;
         cnt_base_q <= cnt_base_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         cnt_q       <= '0;
         mode_q      <= '0;
         busy_q      <= 1'b0;
         hlda_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         busy_q      <= busy_d;
         hlda_lost_q <= hlda_lost_d;
      end
   end

   // Handshake: DREQ is a level request; HRQ is held from REQ through UPD and the bus is
   // owned once HLDA is seen in REQ. Losing HLDA later only ends the burst after UPD.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      busy_d      = busy_q;
      hlda_lost_d = hlda_lost_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               src_d  = src_base;
               dst_d  = dst_base;
               cnt_d  = count_base;
               mode_d = mode;
               busy_d = 1'b1;
            end
            if (busy_q && DREQ) state_d = S_REQ;
         end
         S_REQ: begin
            if (HLDA) begin
               state_d     = S_ADR;
               hlda_lost_d = 1'b0;
            end
         end
         S_ADR: begin
            hlda_lost_d = hlda_lost_q | ~HLDA;
            state_d     = S_RD;
         end
         S_RD: begin
            hlda_lost_d = hlda_lost_q | ~HLDA;
            if (READY) state_d = (mode_q == MODE_MEM2MEM) ? S_WR : S_UPD;
         end
         S_WR: begin
            hlda_lost_d = hlda_lost_q | ~HLDA;
            if (READY) state_d = S_UPD;
         end
         S_UPD: begin
            src_d = addr_dec ? (src_q - A_ONE) : (src_q + A_ONE);
            if (mode_q == MODE_MEM2MEM) dst_d = addr_dec ? (dst_q - A_ONE) : (dst_q + A_ONE);
            if (cnt_q == '0) begin
`ifdef DMA_AUTOINIT_EN
               src_d = src_base_q;
               dst_d = dst_base_q;
               cnt_d = cnt_base_q;
`else
               busy_d = 1'b0;
`endif
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q - C_ONE;
               state_d = (DREQ && !hlda_lost_q) ? S_ADR : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes decode from the registered state, so a reset releases them on the next edge.
   always_comb begin
      HRQ       = (state_q != S_IDLE);
      ADDR      = (state_q == S_WR) ? dst_q : src_q;
      IOR       = 1'b1;
      IOW       = 1'b1;
      MEMR      = 1'b1;
      MEMW      = 1'b1;
      MEMRW     = 1'b0;
      Data_flag = 1'b0;
      IReady    = 1'b0;
      TC        = 1'b0;
      case (state_q)
         S_RD: begin
            case (mode_q)
               MODE_IO2MEM: begin
                  IOR   = 1'b0;
                  MEMW  = 1'b0;
                  MEMRW = 1'b1;
               end
               MODE_MEM2IO: begin
                  MEMR = 1'b0;
                  IOW  = 1'b0;
               end
               MODE_MEM2MEM: begin
                  MEMR   = 1'b0;
                  IReady = READY;
               end
               default: ;
            endcase
         end
         S_WR: begin
            MEMW      = 1'b0;
            MEMRW     = 1'b1;
            Data_flag = 1'b1;
         end
         S_UPD: TC = (cnt_q == '0);
         default: ;
      endcase
   end

   assign busy      = busy_q;
   assign MemToMem  = (mode_q == MODE_MEM2MEM) && busy_q;
   assign dbg_state = 3'(state_q);

endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// Bench for dma_transfer_ctrl: scripted phases build an expected output trace per cycle,
// a negedge compare process checks it, and directed cases pin literal addresses and counts.
`timescale 1ns/1ps
module tb_dma_transfer_ctrl;

   logic        clk = 1'b0;
   logic        RESET, DREQ, HLDA, READY, load, addr_dec;
   logic [15:0] src_base, dst_base, count_base;
   logic [1:0]  mode;
   logic        HRQ, IOR, IOW, MEMR, MEMW, MEMRW, MemToMem, Data_flag, IReady, TC, busy;
   logic [15:0] ADDR;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   dma_transfer_ctrl dut (
      .clk(clk), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .READY(READY), .load(load),
      .src_base(src_base), .dst_base(dst_base), .count_base(count_base), .mode(mode),
      .addr_dec(addr_dec), .HRQ(HRQ), .ADDR(ADDR), .IOR(IOR), .IOW(IOW), .MEMR(MEMR),
      .MEMW(MEMW), .MEMRW(MEMRW), .MemToMem(MemToMem), .Data_flag(Data_flag),
      .IReady(IReady), .TC(TC), .busy(busy), .dbg_state(dbg_state)
   );

   typedef struct packed {
      logic        hrq, ior, iow, memr, memw, memrw, m2m, dflag, irdy, tc, busy, addr_v;
      logic [15:0] addr;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;

   logic [15:0] m_src, m_dst, m_cnt, m_sb, m_db, m_cb;
   logic [1:0]  m_mode;
   logic        m_busy;

   logic [15:0] ior_log[$], memr_log[$], memw_log[$];
   int          irdy_cnt, tc_cnt, dflag_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin : compare
      exp_t e;
      if (!IOR) ior_log.push_back(ADDR);
      if (!MEMR) memr_log.push_back(ADDR);
      if (!MEMW) memw_log.push_back(ADDR);
      if (IReady) irdy_cnt++;
      if (TC) tc_cnt++;
      if (Data_flag) dflag_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("HRQ", 32'(HRQ), 32'(e.hrq));
         chk("IOR", 32'(IOR), 32'(e.ior));
         chk("IOW", 32'(IOW), 32'(e.iow));
         chk("MEMR", 32'(MEMR), 32'(e.memr));
         chk("MEMW", 32'(MEMW), 32'(e.memw));
         chk("MEMRW", 32'(MEMRW), 32'(e.memrw));
         chk("MemToMem", 32'(MemToMem), 32'(e.m2m));
         chk("Data_flag", 32'(Data_flag), 32'(e.dflag));
         chk("IReady", 32'(IReady), 32'(e.irdy));
         chk("TC", 32'(TC), 32'(e.tc));
         chk("busy", 32'(busy), 32'(e.busy));
         if (e.addr_v) chk("ADDR", 32'(ADDR), 32'(e.addr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      ior_log.delete();
      memr_log.delete();
      memw_log.delete();
      irdy_cnt  = 0;
      tc_cnt    = 0;
      dflag_cnt = 0;
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e       = '0;
      e.ior   = 1'b1;
      e.iow   = 1'b1;
      e.memr  = 1'b1;
      e.memw  = 1'b1;
      e.busy  = m_busy;
      e.m2m   = (m_mode == 2'b11) && m_busy;
      return e;
   endfunction

   task automatic model_clear();
      m_src = '0; m_dst = '0; m_cnt = '0; m_sb = '0; m_db = '0; m_cb = '0;
      m_mode = '0; m_busy = 1'b0;
   endtask

   // One idle cycle; go reports whether the channel will request the bus next cycle.
   task automatic idle(input bit dreq, input bit ld, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] c, input logic [1:0] md, output bit go);
      DREQ = dreq; HLDA = 1'b0; READY = 1'($urandom_range(0, 1)); load = ld;
      src_base = s; dst_base = d; count_base = c; mode = md;
      exp_q.push_back(idle_exp());
      go = m_busy && dreq;
      if (ld) begin
         m_src = s; m_dst = d; m_cnt = c; m_mode = md;
         m_sb = s; m_db = d; m_cb = c; m_busy = 1'b1;
      end
      tick();
      load = 1'b0;
   endtask

   // Grant after gdelay REQ cycles, then run transfers until TC, DREQ low or HLDA lost.
   task automatic burst(input int gdelay, input int wfix, input bit hold, input bit allow_drop);
      exp_t e;
      bit   drop, done, cont;
      int   w;
      done = 1'b0;
      for (int g = 0; g < gdelay; g++) begin
         HLDA = 1'b0; load = ($urandom_range(0, 3) == 0);
         src_base = 16'($urandom); count_base = 16'($urandom); mode = 2'($urandom_range(0, 3));
         e = idle_exp(); e.hrq = 1'b1; exp_q.push_back(e); tick();
      end
      HLDA = 1'b1; load = 1'b0;
      e = idle_exp(); e.hrq = 1'b1; exp_q.push_back(e); tick();
      while (!done) begin
         drop = allow_drop && ($urandom_range(0, 7) == 0);
         HLDA = !drop; DREQ = 1'($urandom_range(0, 1)); READY = 1'($urandom_range(0, 1));
         e = idle_exp(); e.hrq = 1'b1; e.addr_v = 1'b1; e.addr = m_src;
         exp_q.push_back(e); tick();
         w = (wfix < 0) ? int'($urandom_range(0, 2)) : wfix;
         for (int i = 0; i <= w; i++) begin
            READY = (i == w); DREQ = 1'($urandom_range(0, 1));
            e = idle_exp(); e.hrq = 1'b1; e.addr_v = 1'b1; e.addr = m_src;
            case (m_mode)
               2'b01: begin e.ior = 1'b0; e.memw = 1'b0; e.memrw = 1'b1; end
               2'b10: begin e.memr = 1'b0; e.iow = 1'b0; end
               2'b11: begin e.memr = 1'b0; e.irdy = READY; end
               default: ;
            endcase
            exp_q.push_back(e); tick();
         end
         if (m_mode == 2'b11) begin
            w = (wfix < 0) ? int'($urandom_range(0, 2)) : 0;
            for (int i = 0; i <= w; i++) begin
               READY = (i == w); DREQ = 1'($urandom_range(0, 1));
               e = idle_exp(); e.hrq = 1'b1; e.addr_v = 1'b1; e.addr = m_dst;
               e.memw = 1'b0; e.memrw = 1'b1; e.dflag = 1'b1;
               exp_q.push_back(e); tick();
            end
         end
         cont = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
         DREQ = cont; READY = 1'($urandom_range(0, 1));
         e = idle_exp(); e.hrq = 1'b1; e.tc = (m_cnt == 16'd0);
         exp_q.push_back(e); tick();
         m_src = addr_dec ? m_src - 16'd1 : m_src + 16'd1;
         if (m_mode == 2'b11) m_dst = addr_dec ? m_dst - 16'd1 : m_dst + 16'd1;
         if (m_cnt == 16'd0) begin
`ifdef DMA_AUTOINIT_EN
            m_src = m_sb; m_dst = m_db; m_cnt = m_cb;
`else
            m_busy = 1'b0;
`endif
            done = 1'b1;
         end else begin
            m_cnt = m_cnt - 16'd1;
            done  = !(cont && !drop);
         end
      end
      HLDA = 1'b0;
      DREQ = 1'b0;
   endtask

   initial begin : driver
      bit   go;
      exp_t e;
      RESET = 1'b1; DREQ = 1'b0; HLDA = 1'b0; READY = 1'b1; load = 1'b0; addr_dec = 1'b0;
      src_base = '0; dst_base = '0; count_base = '0; mode = '0;
      model_clear();
      clear_logs();
      tick(); tick();
      chk("rst_HRQ", 32'(HRQ), 32'd0);
      chk("rst_IOR", 32'(IOR), 32'd1);
      chk("rst_MEMW", 32'(MEMW), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_TC", 32'(TC), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      RESET = 1'b0;

      // I/O->mem, three transfers, grant one cycle after HRQ
      idle(1'b0, 1'b1, 16'h1000, 16'h0, 16'd2, 2'b01, go);
      clear_logs();
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      burst(1, 0, 1'b1, 1'b0);
      chk("t1_ior_count", 32'(ior_log.size()), 32'd3);
      chk("t1_addr0", 32'(ior_log[0]), 32'h1000);
      chk("t1_addr1", 32'(ior_log[1]), 32'h1001);
      chk("t1_addr2", 32'(ior_log[2]), 32'h1002);
      chk("t1_tc_pulses", 32'(tc_cnt), 32'd1);
      chk("t1_hrq_after", 32'(HRQ), 32'd0);
`ifdef DMA_AUTOINIT_EN
      chk("t1_busy_after", 32'(busy), 32'd1);
`else
      chk("t1_busy_after", 32'(busy), 32'd0);
`endif

      // mem->mem single transfer
      idle(1'b0, 1'b1, 16'h2000, 16'h3000, 16'd0, 2'b11, go);
      clear_logs();
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      burst(0, 0, 1'b1, 1'b0);
      chk("t2_memr_count", 32'(memr_log.size()), 32'd1);
      chk("t2_memr_addr", 32'(memr_log[0]), 32'h2000);
      chk("t2_memw_count", 32'(memw_log.size()), 32'd1);
      chk("t2_memw_addr", 32'(memw_log[0]), 32'h3000);
      chk("t2_ireaady_pulses", 32'(irdy_cnt), 32'd1);
      chk("t2_dflag_cycles", 32'(dflag_cnt), 32'd1);

      // mem->I/O with three wait states per read
      idle(1'b0, 1'b1, 16'h0100, 16'h0, 16'd1, 2'b10, go);
      clear_logs();
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      burst(0, 3, 1'b1, 1'b0);
      chk("t3_memr_cycles", 32'(memr_log.size()), 32'd8);
      chk("t3_addr_first", 32'(memr_log[0]), 32'h0100);
      chk("t3_addr_held", 32'(memr_log[3]), 32'h0100);
      chk("t3_addr_second", 32'(memr_log[4]), 32'h0101);
      chk("t3_tc_pulses", 32'(tc_cnt), 32'd1);

      // address wrap both directions
      idle(1'b0, 1'b1, 16'hFFFF, 16'h0, 16'd1, 2'b01, go);
      clear_logs();
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      burst(0, 0, 1'b1, 1'b0);
      chk("t4_inc_wrap", 32'(ior_log[1]), 32'h0000);
      addr_dec = 1'b1;
      idle(1'b0, 1'b1, 16'h0000, 16'h0, 16'd1, 2'b01, go);
      clear_logs();
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      burst(0, 0, 1'b1, 1'b0);
      chk("t4_dec_first", 32'(ior_log[0]), 32'h0000);
      chk("t4_dec_wrap", 32'(ior_log[1]), 32'hFFFF);
      addr_dec = 1'b0;

      // load during REQ is ignored; reset during a read aborts immediately
      idle(1'b0, 1'b1, 16'h5000, 16'h0, 16'd3, 2'b10, go);
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      HLDA = 1'b1; load = 1'b1; src_base = 16'hAAAA; count_base = 16'd0; mode = 2'b11;
      e = idle_exp(); e.hrq = 1'b1; exp_q.push_back(e); tick();
      load = 1'b0;
      e = idle_exp(); e.hrq = 1'b1; e.addr_v = 1'b1; e.addr = m_src; exp_q.push_back(e);
      chk("t5_load_ignored_addr", 32'(ADDR), 32'h5000);
      chk("t5_load_ignored_m2m", 32'(MemToMem), 32'd0);
      tick();
      READY = 1'b0; RESET = 1'b1;
      e = idle_exp(); e.hrq = 1'b1; e.addr_v = 1'b1; e.addr = m_src; e.memr = 1'b0; e.iow = 1'b0;
      exp_q.push_back(e);
      chk("t5_rd_memr", 32'(MEMR), 32'd0);
      tick();
      RESET = 1'b0; HLDA = 1'b0;
      model_clear();
      chk("t5_memr_released", 32'(MEMR), 32'd1);
      chk("t5_iow_released", 32'(IOW), 32'd1);
      chk("t5_hrq", 32'(HRQ), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_state", 32'(dbg_state), 32'd0);
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);

`ifdef DMA_AUTOINIT_EN
      idle(1'b0, 1'b1, 16'h4000, 16'h0, 16'd1, 2'b01, go);
      clear_logs();
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      burst(0, 0, 1'b1, 1'b0);
      chk("t6_tc_pulses", 32'(tc_cnt), 32'd1);
      chk("t6_busy_kept", 32'(busy), 32'd1);
      clear_logs();
      idle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      burst(0, 0, 1'b1, 1'b0);
      chk("t6_rearm_addr", 32'(ior_log[0]), 32'h4000);
`endif

      // randomized traffic
      for (int it = 0; it < 60; it++) begin
         addr_dec = 1'($urandom_range(0, 1));
         if (!m_busy || $urandom_range(0, 3) == 0)
            idle(1'b0, 1'b1,
                 ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 2)) : 16'($urandom),
                 16'($urandom), 16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), go);
         for (int k = 0; k < 4; k++) begin
            idle(1'($urandom_range(0, 1)), 1'b0, 16'($urandom), 16'($urandom),
                 16'($urandom), 2'($urandom_range(0, 3)), go);
            if (go) burst($urandom_range(0, 2), -1, 1'b0, 1'b1);
         end
      end

      for (int k = 0; k < 3; k++) idle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, go);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
